dec_ram_reader: RTL and testbench
=================================

# dec_ram_reader

Streams one stored frame out of a bank of the two-bank decoder RAM (`DEC_RAM`, 1-bit data, synchronous read) onto a valid/ready bit stream. It is the read-side master of that RAM port and sits between the decoder RAM and the hard-decision output interface. It owns the one-cycle RAM read latency and downstream backpressure, so the core only supplies `start` and a bank select.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: RAM address width; must match the RAM instance.
- `DATA_WIDTH`, 1: RAM word width; must match the RAM instance.
- `FRAME_LEN`, 256: words per frame, 1..2^ADDR_WIDTH.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a frame read; sampled only in IDLE.
- `bank`  in  1: bank to read; latched with `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1: one-cycle pulse after the last beat is accepted downstream.
- `ram_address`  out  ADDR_WIDTH: RAM address.
- `ram_cs`  out  1: RAM chip select; one read per asserted cycle.
- `ram_we`  out  1: tied 0; this block never writes.
- `ram_rs`  out  1: RAM bank select; equals the latched `bank`.
- `ram_data_out`  in  DATA_WIDTH: RAM read data, valid the cycle after `ram_cs`.
- `m_data`  out  DATA_WIDTH: output word.
- `m_valid`  out  1: output beat valid.
- `m_ready`  in  1: downstream accepts the beat.
- `m_last`  out  1: marks beat FRAME_LEN-1; qualified by `m_valid`.

## Operation
- FSM states:
  - IDLE: `start` moves the FSM to READ and latches `bank`, addr counter=0, beat counter=0. `start` in any other state is ignored.
  - READ: issues reads. Moves to DRAIN in the cycle the read for address FRAME_LEN-1 is issued.
  - DRAIN: waits for the last beat handshake, then moves to DONE.
  - DONE: pulses `done` for one cycle, then returns to IDLE.
- Read issue rule: `ram_cs`=1 only when (issued-not-captured reads + FIFO occupancy) < 3. This guarantees no RAM data is ever dropped, because the RAM output is not held.
- Captured read: the cycle after `ram_cs`, `ram_data_out` is pushed into a 3-entry FIFO.
- FIFO output: `m_valid` = FIFO not empty; `m_data` = FIFO head. A pop happens on `m_valid & m_ready`.
- `m_last` is high when the beat counter = FRAME_LEN-1.
- `ram_address` increments by 1 per issued read. It stops at FRAME_LEN-1 and never wraps within a frame.
- Counter widths are ADDR_WIDTH+1 so that FRAME_LEN = 2^ADDR_WIDTH is representable.
- Reset values: state IDLE, `busy`=0, `done`=0, `ram_cs`=0, `ram_we`=0, `ram_rs`=0, `ram_address`=0, `m_valid`=0, `m_last`=0, `m_data`=0, FIFO empty, counters 0.
- Reset mid-frame: all of the above on the next edge. The FIFO is flushed, in-flight data is discarded, and no `done` is produced.
- Simultaneous capture and pop is allowed, and occupancy is unchanged. If `m_valid` is held with `m_ready` low, `m_data` and `m_last` must not change.

## Timing
- All outputs are registered; no combinational path from `m_ready` to `ram_cs`.
- `start` sampled at edge 0 → `ram_cs`=1, address 0 in cycle 1 → RAM data in cycle 2 → captured, `m_valid`=1 in cycle 3. Start-to-first-beat latency is 3 cycles.
- With `m_ready` held high, the block sustains 1 beat/cycle. Beat i appears in cycle 3+i, the last beat in cycle FRAME_LEN+2, and `done` in cycle FRAME_LEN+3.
- Back-to-back frames are supported. The earliest next `start` accepted is the cycle after `done`.

## Structure
- Package `dec_ram_pkg` holds:
  - the FSM state enum (IDLE, READ, DRAIN, DONE);
  - the constant FIFO_DEPTH=3;
  - the credit-limit constant.
- Sub-module `dec_ram_rd_fifo`: a 3-entry synchronous FIFO with push, pop, occupancy and empty outputs. The top level holds the FSM, counters and credit logic.

## Test plan
- Basic frame: FRAME_LEN=8, bank 1 preloaded with 1,0,1,1,0,0,1,0, `m_ready`=1, `start` at cycle 0.
  - Beats appear in cycles 3..10 with that data, `m_last` in cycle 10, `done` in cycle 11.
  - `ram_rs`=1 and `ram_we`=0 throughout.
- Backpressure: `m_ready` toggles 1,0,0,1,…
  - All 8 beats are delivered in order with none lost or duplicated.
  - `m_data` is stable while stalled.
  - `ram_cs` never fires with 3 reads outstanding plus held.
- Full depth: FRAME_LEN=256, `m_ready`=1.
  - Address runs 0..255 with no wrap.
  - `m_last` occurs only on beat 255, and `done` in cycle 259.
- Reset mid-frame: assert `rst` at beat 4.
  - Next cycle: `busy`=0, `m_valid`=0, `ram_cs`=0, no `done`.
  - A new `start` reads the frame from address 0 correctly.
- Ignored start: pulse `start` with `bank`=0 during a bank-1 frame.
  - No effect; `ram_rs` stays 1 and the frame completes normally.
- Back-to-back frames: `start` in the cycle after `done`, selecting the other bank.
  - The second frame's first beat appears 3 cycles later with the correct bank data.

Source files
------------

// File: rtl/dec_ram_reader_pkg.sv
//==============================================================================
// Module      : dec_ram_pkg
// Description : Shared types and constants for the decoder RAM frame reader.
//               Holds the reader FSM state encoding, the output FIFO depth
//               and the read-credit limit derived from it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dec_ram_pkg;

   // Reader FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Output FIFO depth. Three entries cover the one-cycle RAM latency plus
   // the registered issue decision, so full throughput survives a stall.
   localparam int FIFO_DEPTH   = 3;

   // Reads in flight plus FIFO occupancy must stay below this before a new
   // read is issued; the RAM does not hold its output, so nothing may be
   // read that has no FIFO slot waiting for it.
   localparam int CREDIT_LIMIT = FIFO_DEPTH;

   // Occupancy (0..FIFO_DEPTH) and pointer (0..FIFO_DEPTH-1) widths.
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/dec_ram_reader_if.sv
//==============================================================================
// Module      : dec_ram_reader_if
// Description : Bus bundle for the frame reader: the read side of the
//               decoder RAM port and the valid/ready output bit stream.
//   ram_address / ram_cs / ram_we / ram_rs : RAM request (reader drives)
//   ram_data_out                            : RAM read data (RAM drives)
//   m_data / m_valid / m_last               : output beat (reader drives)
//   m_ready                                 : downstream accept
//   modport master : reader side;  modport slave : RAM + sink side
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dec_ram_reader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 1
);
   logic [ADDR_WIDTH-1:0] ram_address;
   logic                  ram_cs;
   logic                  ram_we;
   logic                  ram_rs;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output ram_address, ram_cs, ram_we, ram_rs,
      input  ram_data_out,
      output m_data, m_valid, m_last,
      input  m_ready
   );

   modport slave (
      input  ram_address, ram_cs, ram_we, ram_rs,
      output ram_data_out,
      input  m_data, m_valid, m_last,
      output m_ready
   );
endinterface

`default_nettype wire

// File: rtl/dec_ram_reader_rd_fifo.sv
//==============================================================================
// Module      : dec_ram_rd_fifo
// Description : Small synchronous FIFO of FIFO_DEPTH entries that buffers
//               captured RAM words ahead of the output stream.
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   i_push     : write i_din this cycle
//   i_din      : data to write
//   i_pop      : remove head this cycle (ignored when empty)
//   o_dout     : head entry (registered storage)
//   o_count    : current occupancy
//   o_empty    : occupancy is zero
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dec_ram_rd_fifo
   import dec_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 1
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_push,
   input  wire logic [DATA_WIDTH-1:0] i_din,
   input  wire logic                  i_pop,
   output logic      [DATA_WIDTH-1:0] o_dout,
   output logic      [OCC_W-1:0]      o_count,
   output logic                       o_empty
);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [OCC_W-1:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == OCC_W'(FIFO_DEPTH));
   assign w_do_pop  = i_pop & ~w_empty;
   // A push into a full FIFO is only legal when the head leaves together.
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/dec_ram_reader.sv
//==============================================================================
// Module      : dec_ram_reader
// Description : Streams one FRAME_LEN-word frame out of one bank of the
//               two-bank decoder RAM onto a valid/ready stream. Absorbs the
//               one-cycle RAM read latency and downstream backpressure.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a frame (sampled in IDLE only)
//   bank       : bank to read, latched with start
//   busy       : frame in progress (cycle after start .. done inclusive)
//   done       : one-cycle pulse after the last beat is accepted
//   bus        : RAM read port and output stream (master modport)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dec_ram_reader
   import dec_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 1,
   parameter int FRAME_LEN  = 256
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         start,
   input  wire logic         bank,
   output logic              busy,
   output logic              done,
   dec_ram_reader_if.master  bus
);

   // One extra bit so that FRAME_LEN = 2**ADDR_WIDTH is representable.
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_addr;
   logic [CNT_W-1:0] w_addr_next;
   logic [CNT_W-1:0] r_beat;
   logic [CNT_W-1:0] w_beat_next;
   logic             r_bank;
   logic             w_bank_next;
   logic             r_cs;
   logic             w_cs_next;
   logic             r_push;
   logic             r_busy;
   logic             r_done;
   logic             r_last;
   logic             w_last_next;

   logic [DATA_WIDTH-1:0] w_fifo_dout;
   logic [OCC_W-1:0]      w_occ;
   logic                  w_empty;
   logic                  w_pop;
   logic [OCC_W:0]        w_occ_next;
   logic                  w_credit_ok;

   // r_push is the read issued last cycle: its data is on the RAM output now.
   dec_ram_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_push),
      .i_din   (bus.ram_data_out),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_count (w_occ),
      .o_empty (w_empty)
   );

   assign w_pop = ~w_empty & bus.m_ready;

   // Decide next cycle's chip select. Occupancy next cycle plus the read
   // still in flight then (this cycle's r_cs) must leave room for one more.
   assign w_occ_next  = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_push}
                        - {{OCC_W{1'b0}}, w_pop};
   assign w_credit_ok = (w_occ_next + {{OCC_W{1'b0}}, r_cs})
                        < (OCC_W + 1)'(CREDIT_LIMIT);

   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_addr;
      w_beat_next  = r_beat;
      w_bank_next  = r_bank;
      w_cs_next    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_READ;
               w_bank_next  = bank;
               w_addr_next  = '0;
               w_beat_next  = '0;
               w_cs_next    = w_credit_ok;
            end
         end
         ST_READ: begin
            if (w_pop) begin
               w_beat_next = r_beat + c_one;
            end
            // The address parks on the last word rather than wrapping.
            if (r_cs && (r_addr == c_last)) begin
               w_state_next = ST_DRAIN;
            end else begin
               if (r_cs) begin
                  w_addr_next = r_addr + c_one;
               end
               w_cs_next = w_credit_ok;
            end
         end
         ST_DRAIN: begin
            if (w_pop) begin
               w_beat_next = r_beat + c_one;
               if (r_last) begin
                  w_state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // m_last only moves on a pop, so it holds steady through a stall.
   assign w_last_next = (w_beat_next == c_last) &&
                        ((w_state_next == ST_READ) || (w_state_next == ST_DRAIN));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_beat  <= '0;
         r_bank  <= 1'b0;
         r_cs    <= 1'b0;
         r_push  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_addr  <= w_addr_next;
         r_beat  <= w_beat_next;
         r_bank  <= w_bank_next;
         r_cs    <= w_cs_next;
         r_push  <= r_cs;
         r_busy  <= (w_state_next != ST_IDLE);
         r_done  <= (w_state_next == ST_DONE);
         r_last  <= w_last_next;
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign bus.ram_address = r_addr[ADDR_WIDTH-1:0];
   assign bus.ram_cs      = r_cs;
   assign bus.ram_we      = 1'b0;
   assign bus.ram_rs      = r_bank;
   assign bus.m_data      = w_fifo_dout;
   assign bus.m_valid     = ~w_empty;
   assign bus.m_last      = r_last;

endmodule

`default_nettype wire

// File: tb/tb_dec_ram_reader.sv
//==============================================================================
// Module      : tb_dec_ram_reader
// Description : Directed self-checking bench for dec_ram_reader. Two DUTs
//               share one RAM image: an 8-word-frame instance and a
//               256-word-frame instance.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dec_ram_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start8, bank8, busy8, done8;
   logic start256, bank256, busy256, done256;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] pat1 = 8'b10110010;   // bank 1 words 0..7, word 0 is MSB
   logic [7:0] pat0 = 8'b01101001;   // bank 0 words 0..7

   logic ram_mem [0:1][0:255];

   dec_ram_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(1)) bus8 ();
   dec_ram_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(1)) bus256 ();

   dec_ram_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(1), .FRAME_LEN(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .bank  (bank8),
      .busy  (busy8),
      .done  (done8),
      .bus   (bus8.master)
   );

   dec_ram_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(1), .FRAME_LEN(256)) dut256 (
      .clk   (clk),
      .rst   (rst),
      .start (start256),
      .bank  (bank256),
      .busy  (busy256),
      .done  (done256),
      .bus   (bus256.master)
   );

   // Synchronous-read RAM models, data valid the cycle after chip select.
   always @(posedge clk) begin
      if (bus8.ram_cs && !bus8.ram_we)
         bus8.ram_data_out <= ram_mem[bus8.ram_rs][bus8.ram_address];
   end
   always @(posedge clk) begin
      if (bus256.ram_cs && !bus256.ram_we)
         bus256.ram_data_out <= ram_mem[bus256.ram_rs][bus256.ram_address];
   end

   // Expected RAM contents.
   function automatic logic exp_bit(input int b, input int a);
      logic [7:0] av;
      av = a[7:0];
      if (a < 8) return (b == 1) ? pat1[7 - a] : pat0[7 - a];
      return (^(av & 8'hA5)) ^ b[0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      rst = 1'b1;
      repeat (3) tick();
      got = {busy8, done8, bus8.ram_cs, bus8.ram_we, bus8.ram_rs,
             bus8.m_valid, bus8.m_last, bus8.m_data[0]};
      n_cmp++;
      if (got !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 00000000", got);
      end
      n_cmp++;
      if (bus8.ram_address !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_addr: got %0d want 0", bus8.ram_address);
      end
      n_cmp++;
      if ({busy256, done256, bus256.ram_cs, bus256.m_valid} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_dut256: got %b want 0000",
                  {busy256, done256, bus256.ram_cs, bus256.m_valid});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [4:0] got, want;
      bus8.m_ready = 1'b1;
      bank8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         got  = {busy8, done8, bus8.ram_cs, bus8.m_valid, bus8.m_last};
         want = {(c <= 11), (c == 11), (c <= 8), (c >= 3 && c <= 10), (c == 10)};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL basic_ctrl c=%0d: got %b want %b", c, got, want);
         end
         n_cmp++;
         if ({bus8.ram_rs, bus8.ram_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_rs_we c=%0d: got %b want 10", c, {bus8.ram_rs, bus8.ram_we});
         end
         if (c <= 8) begin
            n_cmp++;
            if (bus8.ram_address !== 8'(c - 1)) begin
               n_fail++;
               $display("FAIL basic_addr c=%0d: got %0d want %0d", c, bus8.ram_address, c - 1);
            end
         end
         if (c >= 3 && c <= 10) begin
            n_cmp++;
            if (bus8.m_data[0] !== exp_bit(1, c - 3)) begin
               n_fail++;
               $display("FAIL basic_data c=%0d: got %b want %b", c, bus8.m_data[0], exp_bit(1, c - 3));
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int   idx, occ;
      logic prev_cs, prev_stall, prev_data, prev_last, pop, seen_done;
      idx = 0; occ = 0;
      prev_cs = 1'b0; prev_stall = 1'b0; prev_data = 1'b0; prev_last = 1'b0;
      seen_done = 1'b0;
      bus8.m_ready = 1'b1;
      bank8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 80 && !seen_done; c++) begin
         bus8.m_ready = ((c - 1) % 3 == 0);
         n_cmp++;
         if (bus8.m_valid !== (occ != 0)) begin
            n_fail++;
            $display("FAIL bp_valid c=%0d: got %b want %b", c, bus8.m_valid, (occ != 0));
         end
         if (prev_stall) begin
            n_cmp++;
            if ({bus8.m_data[0], bus8.m_last} !== {prev_data, prev_last}) begin
               n_fail++;
               $display("FAIL bp_stable c=%0d: got %b want %b", c,
                        {bus8.m_data[0], bus8.m_last}, {prev_data, prev_last});
            end
         end
         if (bus8.ram_cs) begin
            n_cmp++;
            if (occ + int'(prev_cs) >= 3) begin
               n_fail++;
               $display("FAIL bp_credit c=%0d: got held+inflight %0d want <3", c, occ + int'(prev_cs));
            end
         end
         pop = bus8.m_valid & bus8.m_ready;
         if (pop) begin
            n_cmp++;
            if ({bus8.m_data[0], bus8.m_last} !== {exp_bit(1, idx), (idx == 7)}) begin
               n_fail++;
               $display("FAIL bp_beat idx=%0d: got %b want %b", idx,
                        {bus8.m_data[0], bus8.m_last}, {exp_bit(1, idx), (idx == 7)});
            end
            idx++;
         end
         if (done8) seen_done = 1'b1;
         prev_stall = bus8.m_valid & ~bus8.m_ready;
         prev_data  = bus8.m_data[0];
         prev_last  = bus8.m_last;
         occ        = occ + int'(prev_cs) - int'(pop);
         prev_cs    = bus8.ram_cs;
         tick();
      end
      n_cmp++;
      if (idx !== 8 || !seen_done) begin
         n_fail++;
         $display("FAIL bp_complete: got beats=%0d done=%b want beats=8 done=1", idx, seen_done);
      end
      bus8.m_ready = 1'b1;
      tick();
   endtask

   task automatic test_full_depth();
      logic [3:0] got, want;
      bus256.m_ready = 1'b1;
      bank256 = 1'b0; start256 = 1'b1;
      tick();
      start256 = 1'b0;
      for (int c = 1; c <= 261; c++) begin
         got  = {bus256.ram_cs, bus256.m_valid, bus256.m_last, done256};
         want = {(c <= 256), (c >= 3 && c <= 258), (c == 258), (c == 259)};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL full_ctrl c=%0d: got %b want %b", c, got, want);
         end
         n_cmp++;
         if (bus256.ram_address !== ((c <= 256) ? 8'(c - 1) : 8'd255)) begin
            n_fail++;
            $display("FAIL full_addr c=%0d: got %0d want %0d", c, bus256.ram_address,
                     (c <= 256) ? c - 1 : 255);
         end
         if (c >= 3 && c <= 258) begin
            n_cmp++;
            if (bus256.m_data[0] !== exp_bit(0, c - 3)) begin
               n_fail++;
               $display("FAIL full_data c=%0d: got %b want %b", c, bus256.m_data[0], exp_bit(0, c - 3));
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      bus8.m_ready = 1'b1;
      bank8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c < 7; c++) tick();
      rst = 1'b1;                       // cycle 7: beat 4 on the stream
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({busy8, bus8.m_valid, bus8.ram_cs, done8} !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid_flush k=%0d: got %b want 0000", k,
                     {busy8, bus8.m_valid, bus8.ram_cs, done8});
         end
         tick();
      end
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         if (c == 1) begin
            n_cmp++;
            if ({bus8.ram_cs, bus8.ram_address} !== {1'b1, 8'd0}) begin
               n_fail++;
               $display("FAIL rstmid_restart_addr: got cs=%b addr=%0d want cs=1 addr=0",
                        bus8.ram_cs, bus8.ram_address);
            end
         end
         n_cmp++;
         if ({bus8.m_valid, done8} !== {(c >= 3 && c <= 10), (c == 11)}) begin
            n_fail++;
            $display("FAIL rstmid_ctrl c=%0d: got %b want %b", c, {bus8.m_valid, done8},
                     {(c >= 3 && c <= 10), (c == 11)});
         end
         if (c >= 3 && c <= 10) begin
            n_cmp++;
            if (bus8.m_data[0] !== exp_bit(1, c - 3)) begin
               n_fail++;
               $display("FAIL rstmid_data c=%0d: got %b want %b", c, bus8.m_data[0], exp_bit(1, c - 3));
            end
         end
         tick();
      end
      tick();
   endtask

   task automatic test_ignored_start();
      bus8.m_ready = 1'b1;
      bank8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         // Stray starts during READ and during DONE must both be ignored.
         if (c == 4 || c == 11) begin start8 = 1'b1; bank8 = 1'b0; end
         else begin start8 = 1'b0; bank8 = 1'b1; end
         n_cmp++;
         if ({busy8, done8, bus8.ram_rs} !== {(c <= 11), (c == 11), 1'b1}) begin
            n_fail++;
            $display("FAIL ign_ctrl c=%0d: got %b want %b", c, {busy8, done8, bus8.ram_rs},
                     {(c <= 11), (c == 11), 1'b1});
         end
         if (c >= 3 && c <= 10) begin
            n_cmp++;
            if ({bus8.m_valid, bus8.m_data[0]} !== {1'b1, exp_bit(1, c - 3)}) begin
               n_fail++;
               $display("FAIL ign_data c=%0d: got %b want %b", c, {bus8.m_valid, bus8.m_data[0]},
                        {1'b1, exp_bit(1, c - 3)});
            end
         end
         tick();
      end
      start8 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0] got, want;
      logic       exp_v;
      bus8.m_ready = 1'b1;
      bank8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         if (c == 12) begin start8 = 1'b1; bank8 = 1'b0; end
         else start8 = 1'b0;
         exp_v = (c >= 3 && c <= 10) || (c >= 15 && c <= 22);
         got  = {busy8, done8, bus8.m_valid, bus8.m_last, bus8.ram_rs};
         want = {(c <= 11) || (c >= 13 && c <= 23), (c == 11) || (c == 23), exp_v,
                 (c == 10) || (c == 22), (c <= 12)};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL b2b_ctrl c=%0d: got %b want %b", c, got, want);
         end
         if (exp_v) begin
            n_cmp++;
            if (bus8.m_data[0] !== ((c <= 10) ? exp_bit(1, c - 3) : exp_bit(0, c - 15))) begin
               n_fail++;
               $display("FAIL b2b_data c=%0d: got %b want %b", c, bus8.m_data[0],
                        (c <= 10) ? exp_bit(1, c - 3) : exp_bit(0, c - 15));
            end
         end
         tick();
      end
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++)
            ram_mem[b][a] = exp_bit(b, a);
      rst = 1'b1;
      start8 = 1'b0; bank8 = 1'b0;
      start256 = 1'b0; bank256 = 1'b0;
      bus8.m_ready = 1'b0;
      bus256.m_ready = 1'b0;

      test_reset();
      test_basic();
      test_backpressure();
      test_full_depth();
      test_reset_mid();
      test_ignored_start();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
